clock_divider_checker: RTL

- Receive-side monitor for divided clocks produced by the team's clock dividers.
- Samples a divided clock (in_clk) as data in the fast clk domain and measures its period and high time.
- Reports lock when the measured waveform matches the expected DIV ratio with 50% duty, and flags period/duty errors and a stopped divided clock.
- Used in bring-up and BIST to verify divider outputs.

---
 rtl/clock_divider_checker.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/clock_divider_checker.sv
// Receive-side monitor for a divided clock: samples in_clk in the clk domain, measures
// period and high time, and reports lock, period/duty errors and a stopped clock.
module clock_divider_checker #(
    parameter int DIV      = 4,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_clk,
    output logic             locked,
    output logic             period_err,
    output logic             timeout,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] DIV_V     = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] HALF_V    = CNT_W'(DIV / 2);
    localparam logic [GC_W-1:0]  LOCK_V    = GC_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic             s3;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hi_len;
    logic             hi_seen;
    logic [GC_W-1:0]  good_cnt;
    logic             rise;
    logic             fall;
    logic             good;
    logic [CNT_W-1:0] period_now;
    logic [GC_W-1:0]  good_next;

    // Edge detection and evaluation of the period that a rise in this cycle completes
    always_comb begin
        rise       = s2 & ~s3;
        fall       = ~s2 & s3;
        period_now = pcnt + CNT_W'(1);
        good_next  = good_cnt + GC_W'(1);
        good       = (period_now == DIV_V) && hi_seen && (hi_len == HALF_V);
    end

    // Two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= in_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Period and high-time counters; both saturate so a stopped clock cannot wrap them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt    <= '0;
            hcnt    <= '0;
            hi_len  <= '0;
            hi_seen <= 1'b0;
        end else begin
            if (rise) begin
                pcnt    <= '0;
                hcnt    <= '0;
                hi_seen <= 1'b0;
            end else begin
                if (pcnt != TIMEOUT_V) begin
                    pcnt <= pcnt + CNT_W'(1);
                end
                if (s2 && (hcnt != TIMEOUT_V)) begin
                    hcnt <= hcnt + CNT_W'(1);
                end
            end
            if (fall) begin
                hi_len  <= hcnt + CNT_W'(1);
                hi_seen <= 1'b1;
            end
        end
    end

    // Lock FSM with registered status outputs; a rise wins over a timeout in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            good_cnt    <= '0;
            locked      <= 1'b0;
            period_err  <= 1'b0;
            timeout     <= 1'b0;
            meas_period <= '0;
            meas_high   <= '0;
        end else begin
            period_err <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= ACQUIRE;
                        good_cnt <= '0;
                    end
                end
                ACQUIRE: begin
                    if (rise) begin
                        meas_period <= period_now;
                        meas_high   <= hi_len;
                        if (good) begin
                            good_cnt <= good_next;
                            if (good_next == LOCK_V) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            period_err <= 1'b1;
                            good_cnt   <= '0;
                        end
                    end else if (pcnt == TIMEOUT_V) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        meas_period <= period_now;
                        meas_high   <= hi_len;
                        if (!good) begin
                            period_err <= 1'b1;
                            locked     <= 1'b0;
                            good_cnt   <= '0;
                            state      <= ACQUIRE;
                        end
                    end else if (pcnt == TIMEOUT_V) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                end
            endcase
        end
    end

endmodule
